gorev4_histogram_reader: RTL and testbench

Receives the 256-word histogram table (`{bin_index[7:0], count[23:0]}`, bins 0..255 in order) over a valid/ready handshake. While receiving, it builds the cumulative distribution (CDF) and checks the table's integrity. From the CDF it computes a 256-entry 8-bit histogram-equalization LUT using a sequential divider. The downstream pixel-remap stage reads the LUT through a registered read port.

---
 rtl/gorev4_pkg.sv | 25 ++
 rtl/gorev4_histogram_reader_seq_divider.sv | 68 ++++++
 rtl/gorev4_histogram_reader.sv | 162 ++++++++++++++++
 tb/tb_gorev4_histogram_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gorev4_pkg.sv
// Shared constants, FSM state type and table-word layout for the histogram reader.
package gorev4_pkg;

  localparam int unsigned PIXEL_COUNT = 76800;
  localparam int unsigned BIN_COUNT   = 256;
  localparam int unsigned COUNT_W     = 24;
  localparam int unsigned SUM_W       = COUNT_W + 1;
  localparam int unsigned NUM_W       = 32;
  localparam int unsigned LUT_MAX     = 255;

  localparam int unsigned IDX_MSB = 31;
  localparam int unsigned IDX_LSB = 24;
  localparam int unsigned CNT_MSB = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_CHECK,
    ST_DIV_START,
    ST_DIV_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/gorev4_histogram_reader_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so done pulses NUM_W cycles after start.
module seq_divider #(
  parameter int unsigned NUM_W = 32,
  parameter int unsigned DEN_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] quotient_o
);

  localparam int unsigned CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_q, den_q, src_rem, src_den, rem_step;
  logic [NUM_W-1:0] quo_q, src_quo, quo_step;
  logic [DEN_W:0]   shifted;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, qbit;

  always_comb begin
    src_rem  = start_i ? '0    : rem_q;
    src_quo  = start_i ? num_i : quo_q;
    src_den  = start_i ? den_i : den_q;
    shifted  = {src_rem, src_quo[NUM_W-1]};
    qbit     = (shifted >= {1'b0, src_den});
    // The partial remainder is always below the divisor, so DEN_W bits hold it.
    rem_step = qbit ? DEN_W'(shifted - {1'b0, src_den}) : DEN_W'(shifted);
    quo_step = {src_quo[NUM_W-2:0], qbit};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_step;
        quo_q  <= quo_step;
        den_q  <= den_i;
        cnt_q  <= CNT_W'(NUM_W - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/gorev4_histogram_reader.sv
// Histogram table receiver: builds the CDF while checking bin order and total,
// then fills a 256-entry equalization LUT with one sequential division per bin.
module gorev4_histogram_reader
  import gorev4_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             veri_gecerli_i,
  input  logic [31:0]      veri_i,
  output logic             veri_al_o,
  input  logic [7:0]       lut_addr_i,
  output logic [7:0]       lut_data_o,
  output logic [SUM_W-1:0] toplam_o,
  output logic             hata_o,
  output logic             islem_bitti_o
);

  state_e             state_q, state_d;
  logic [7:0]         exp_idx_q, exp_idx_d, k_q, k_d;
  logic [SUM_W-1:0]   toplam_q, toplam_d, cdf_min_q, cdf_min_d;
  logic [COUNT_W-1:0] den_q, den_d;
  logic               hata_q, hata_d, zero_q, zero_d;
  logic [7:0]         lut_data_q;

  logic [SUM_W-1:0] cdf_mem [BIN_COUNT];
  logic [7:0]       lut_mem [BIN_COUNT];

  logic               accept, cdf_we, lut_we;
  logic [7:0]         word_idx, lut_wdata;
  logic [COUNT_W-1:0] word_cnt;
  logic [SUM_W-1:0]   sum_next, cdf_k, spread;
  logic [NUM_W-1:0]   div_num, div_quo;
  logic               div_start, div_busy, div_done;

  assign word_idx = veri_i[IDX_MSB:IDX_LSB];
  assign word_cnt = veri_i[CNT_MSB:0];
  assign sum_next = toplam_q + SUM_W'(word_cnt);
  assign spread   = toplam_q - cdf_min_q;
  assign cdf_k    = cdf_mem[k_q];
  // Bins at or below the first occupied level map to black.
  assign div_num  = (cdf_k <= cdf_min_q) ? '0
                  : NUM_W'(cdf_k - cdf_min_q) * NUM_W'(LUT_MAX);
  assign lut_wdata = zero_q ? 8'd0
                   : (div_quo > NUM_W'(LUT_MAX)) ? 8'(LUT_MAX) : div_quo[7:0];

  seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (COUNT_W)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .num_i      (div_num),
    .den_i      (den_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d   = state_q;
    exp_idx_d = exp_idx_q;
    k_d       = k_q;
    toplam_d  = toplam_q;
    cdf_min_d = cdf_min_q;
    den_d     = den_q;
    hata_d    = hata_q;
    zero_d    = zero_q;
    accept    = 1'b0;
    cdf_we    = 1'b0;
    lut_we    = 1'b0;
    div_start = 1'b0;
    veri_al_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        exp_idx_d = '0;
        toplam_d  = '0;
        cdf_min_d = '0;
        hata_d    = 1'b0;
        if (en_i) state_d = ST_RECEIVE;
      end
      ST_RECEIVE: begin
        veri_al_o = en_i;
        accept    = en_i && veri_gecerli_i;
        if (accept) begin
          cdf_we    = 1'b1;
          toplam_d  = sum_next;
          exp_idx_d = exp_idx_q + 8'd1;
          if (word_idx != exp_idx_q || sum_next[SUM_W-1]) hata_d = 1'b1;
          if (cdf_min_q == '0 && word_cnt != '0) cdf_min_d = sum_next;
          if (exp_idx_q == 8'(BIN_COUNT - 1)) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (toplam_q != SUM_W'(PIXEL_COUNT)) hata_d = 1'b1;
        den_d   = spread[COUNT_W-1:0];
        zero_d  = (spread == '0);
        k_d     = '0;
        state_d = (spread == '0) ? ST_WRITE : ST_DIV_START;
      end
      ST_DIV_START: begin
        if (!div_busy) begin
          div_start = 1'b1;
          state_d   = ST_DIV_WAIT;
        end
      end
      ST_DIV_WAIT: begin
        if (div_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        lut_we = 1'b1;
        k_d    = k_q + 8'd1;
        if (k_q == 8'(BIN_COUNT - 1)) state_d = ST_DONE;
        else                          state_d = zero_q ? ST_WRITE : ST_DIV_START;
      end
      ST_DONE: begin
        if (!en_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      exp_idx_q  <= '0;
      k_q        <= '0;
      toplam_q   <= '0;
      cdf_min_q  <= '0;
      den_q      <= '0;
      hata_q     <= 1'b0;
      zero_q     <= 1'b0;
      lut_data_q <= '0;
    end else begin
      state_q    <= state_d;
      exp_idx_q  <= exp_idx_d;
      k_q        <= k_d;
      toplam_q   <= toplam_d;
      cdf_min_q  <= cdf_min_d;
      den_q      <= den_d;
      hata_q     <= hata_d;
      zero_q     <= zero_d;
      lut_data_q <= (state_q == ST_DONE) ? lut_mem[lut_addr_i] : 8'd0;
    end
  end

  // NOTE: the tables have no reset; each run rewrites every entry before DONE exposes it.
  always_ff @(posedge clk_i) begin
    if (cdf_we) cdf_mem[exp_idx_q] <= sum_next;
    if (lut_we) lut_mem[k_q]       <= lut_wdata;
  end

  assign toplam_o      = toplam_q;
  assign hata_o        = hata_q;
  assign lut_data_o    = lut_data_q;
  assign islem_bitti_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_gorev4_histogram_reader.sv
// Directed bench for the histogram reader: feeds tables, checks receive-side
// sums, completion latency and the equalization LUT against a reference model.
module tb_gorev4_histogram_reader;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, veri_gecerli_i;
  logic [31:0] veri_i;
  logic        veri_al_o;
  logic [7:0]  lut_addr_i, lut_data_o;
  logic [24:0] toplam_o;
  logic        hata_o, islem_bitti_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [23:0] tbl_cnt [256];
  logic [7:0]  tbl_idx [256];
  logic [7:0]  exp_lut [256];
  logic [31:0] sb_q [$];
  logic [31:0] exp_total;
  logic        exp_hata_final;
  int          exp_lat;

  always #5 clk_i = ~clk_i;

  gorev4_histogram_reader dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .veri_gecerli_i (veri_gecerli_i),
    .veri_i         (veri_i),
    .veri_al_o      (veri_al_o),
    .lut_addr_i     (lut_addr_i),
    .lut_data_o     (lut_data_o),
    .toplam_o       (toplam_o),
    .hata_o         (hata_o),
    .islem_bitti_o  (islem_bitti_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill_uniform();
    for (int k = 0; k < 256; k++) begin
      tbl_cnt[k] = 24'd300;
      tbl_idx[k] = 8'(k);
    end
  endtask

  task automatic fill_levels(input int a, input int b, input logic [23:0] c);
    for (int k = 0; k < 256; k++) begin
      tbl_cnt[k] = (k == a || k == b) ? c : 24'd0;
      tbl_idx[k] = 8'(k);
    end
  endtask

  task automatic build_model();
    longint total = 0, cmin = 0, cdf = 0, den;
    logic   idx_err = 1'b0;
    for (int k = 0; k < 256; k++) begin
      total += longint'(tbl_cnt[k]);
      if (cmin == 0 && tbl_cnt[k] != 0) cmin = total;
      if (tbl_idx[k] != 8'(k)) idx_err = 1'b1;
    end
    den            = total - cmin;
    exp_total      = 32'(total);
    exp_hata_final = idx_err || (total != 76800);
    exp_lat        = (den == 0) ? 257 : 8705;
    for (int k = 0; k < 256; k++) begin
      cdf += longint'(tbl_cnt[k]);
      exp_lut[k] = (den == 0 || cdf <= cmin) ? 8'd0 : 8'(((cdf - cmin) * 255) / den);
    end
  endtask

  task automatic send_table(input bit gaps, input bit pause);
    int          i = 0, guard = 0, pause_left = pause ? 20 : 0;
    logic [31:0] run_sum = 0;
    logic        seen_err = 1'b0;
    bit          pend = 0;
    while (i < 256 && guard < 5000) begin
      @(negedge clk_i);
      guard++;
      if (pend) begin
        check("toplam_rx", toplam_o, run_sum);
        check("hata_rx", hata_o, seen_err);
        pend = 0;
      end
      if (pause && i == 100 && pause_left > 0) begin
        en_i = 1'b0;
        pause_left--;
      end else begin
        en_i = 1'b1;
      end
      veri_gecerli_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      veri_i         = {tbl_idx[i], tbl_cnt[i]};
      #1;
      if (pause && pause_left == 10 && !en_i) check("ready_gated", veri_al_o, 0);
      if (veri_gecerli_i && veri_al_o) begin
        run_sum += 32'(tbl_cnt[i]);
        if (tbl_idx[i] != 8'(i)) seen_err = 1'b1;
        i++;
        pend = 1;
      end
    end
    check("rx_words", i, 256);
    @(negedge clk_i);
    veri_gecerli_i = 1'b0;
    if (pend) begin
      check("toplam_rx", toplam_o, run_sum);
      check("hata_rx", hata_o, seen_err);
    end
  endtask

  task automatic wait_done();
    int cyc = 1;
    bit got = 0;
    while (cyc < 12000) begin
      @(negedge clk_i);
      if (cyc == 1) check("hata_after_check", hata_o, exp_hata_final);
      if (islem_bitti_o) begin
        got = 1;
        break;
      end
      cyc++;
    end
    check("latency", got ? cyc : -1, exp_lat);
    check("toplam_done", toplam_o, exp_total);
    check("hata_done", hata_o, exp_hata_final);
  endtask

  task automatic read_lut();
    logic [31:0] expv;
    for (int a = 0; a <= 256; a++) begin
      @(negedge clk_i);
      if (a > 0) begin
        expv = sb_q.pop_front();
        check($sformatf("lut[%0d]", a - 1), lut_data_o, expv);
      end
      if (a < 256) begin
        lut_addr_i = a[7:0];
        sb_q.push_back({24'd0, exp_lut[a]});
      end
    end
  endtask

  task automatic finish_run();
    @(negedge clk_i);
    en_i       = 1'b0;
    lut_addr_i = 8'd200;
    @(negedge clk_i);
    check("bitti_drop", islem_bitti_o, 0);
    @(negedge clk_i);
    check("lut_gated", lut_data_o, 0);
  endtask

  task automatic run_case(input bit gaps, input bit pause);
    build_model();
    send_table(gaps, pause);
    wait_done();
    read_lut();
    finish_run();
  endtask

  initial begin
    rst_i          = 1'b1;
    en_i           = 1'b0;
    veri_gecerli_i = 1'b0;
    veri_i         = '0;
    lut_addr_i     = '0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", veri_al_o, 0);
    check("rst_lut", lut_data_o, 0);
    check("rst_toplam", toplam_o, 0);
    check("rst_hata", hata_o, 0);
    check("rst_bitti", islem_bitti_o, 0);
    rst_i = 1'b0;

    // Uniform table: lut[k] = k.
    fill_uniform();
    run_case(1'b0, 1'b0);

    // Single-level image: degenerate path, all zeros.
    fill_levels(128, 128, 24'd76800);
    run_case(1'b0, 1'b0);

    // Two-level image.
    fill_levels(10, 200, 24'd38400);
    run_case(1'b0, 1'b0);

    // Word 5 carries index 6.
    fill_uniform();
    tbl_idx[5] = 8'd6;
    run_case(1'b0, 1'b0);

    // Valid gaps, enable pause, total one short.
    fill_uniform();
    tbl_cnt[255] = 24'd299;
    run_case(1'b1, 1'b1);

    // Asynchronous reset while dividing bin 77, then a clean rerun.
    fill_uniform();
    build_model();
    send_table(1'b0, 1'b0);
    repeat (2630) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_ready", veri_al_o, 0);
    check("mid_rst_lut", lut_data_o, 0);
    check("mid_rst_toplam", toplam_o, 0);
    check("mid_rst_hata", hata_o, 0);
    check("mid_rst_bitti", islem_bitti_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    en_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    run_case(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
